vedm_window_avg: RTL and testbench
==================================

VEDM_WINDOW_AVG -- requirements
Module: vedm_window_avg

Interface
REQ-001 Parameter: WIN_LOG2, 3, log2 of samples per averaging window; legal range 1..6.
REQ-002 Parameter: ALARM_HI, 8'd200, average at or above which alarm sets.
REQ-003 Parameter: ALARM_LO, 8'd180, average at or below which alarm clears; ALARM_LO < ALARM_HI required.
REQ-004 Port: clk  input  1  single clock, rising edge.
REQ-005 Port: rst  input  1  asynchronous, active-high reset.
REQ-006 Port: ena  input  1  stage enable; low freezes sample acceptance.
REQ-007 Port: s_valid  input  1  sample valid from the upstream registered sample stage.
REQ-008 Port: s_data  input  8  unsigned converter sample.
REQ-009 Port: s_ready  output  1  sample accepted this cycle when s_valid & s_ready.
REQ-010 Port: clr  input  1  synchronous window abort.
REQ-011 Port: avg_valid  output  1  one-cycle pulse; avg_out, peak_max, peak_min and alarm updated.
REQ-012 Port: avg_out  output  8  window average.
REQ-013 Port: peak_max  output  8  window maximum sample.
REQ-014 Port: peak_min  output  8  window minimum sample.
REQ-015 Port: alarm  output  1  hysteretic over-level flag.
REQ-016 Port: busy  output  1  high when state is not IDLE.

Function
REQ-017 FSM states IDLE, ACCUM, REPORT shall be implemented; s_ready = ena & (state != REPORT), combinational.
REQ-018 IDLE: an accepted sample shall load acc = s_data and cnt = 1, and move to ACCUM (WIN_LOG2=1 still passes through ACCUM until cnt = 2).
REQ-019 ACCUM: each accepted sample shall add to acc and increment cnt; the edge accepting sample number 2^WIN_LOG2 shall move to REPORT.
REQ-020 Accumulator width shall be 8+WIN_LOG2 bits; overflow is impossible.
REQ-021 REPORT shall last exactly one cycle regardless of ena; its exit edge shall register avg_out = acc >> WIN_LOG2 (truncating), set avg_valid for one cycle and return to IDLE.
REQ-022 avg_valid shall therefore assert in the second cycle after the edge accepting the final sample.
REQ-023 ena low shall hold state, acc and cnt; gaps with s_valid or ena low shall not alter the result.
REQ-024 clr shall take priority over sample acceptance, return to IDLE, discard the partial window (including in REPORT: no avg_valid), and leave avg_out, peaks and alarm unchanged.
REQ-025 Alarm shall be evaluated only at the avg_valid update: set if new avg >= ALARM_HI, cleared if new avg <= ALARM_LO, otherwise held.

Reset
REQ-026 rst shall asynchronously force state IDLE, acc, cnt, avg_out, peak_max, peak_min, avg_valid, alarm and busy to 0.
REQ-027 rst asserted mid-window shall discard the window; no avg_valid shall follow release.

Configuration
REQ-028 Macro VEDM_PEAK_TRACK_EN defined: per-window running max/min shall be tracked (the first sample loads both) and published to peak_max/peak_min with avg_valid.
REQ-029 Macro undefined: peak tracking logic shall be absent; peak_max and peak_min shall be constant 0; ports remain.

Structure
REQ-030 Package vedm_energy_pkg shall hold the FSM state enum and default ALARM_HI/ALARM_LO constants.
REQ-031 Min/max tracking shall be sub-module vedm_peak_track, instantiated only under VEDM_PEAK_TRACK_EN.

Verification (WIN_LOG2=3, defaults, macro defined unless noted)
REQ-032 Eight samples of 100 back-to-back -> single avg_valid 2 cycles after 8th accept; avg_out=100, max=min=100, alarm=0.
REQ-033 Samples 1..8 with random s_valid/ena gaps -> avg_out=4 (36>>3), peak_max=8, peak_min=1; s_ready low in REPORT cycle.
REQ-034 Eight samples of 255 -> avg_out=255, no wrap, alarm=1.
REQ-035 Successive windows averaging 200, 190, 181, 180 -> alarm 1, 1, 1, 0.
REQ-036 clr after 5 samples, then eight samples of 50 -> no pulse for the aborted window, then avg_out=50; async rst mid-window -> all outputs 0 immediately, no pulse after release.
REQ-037 Macro undefined, samples 1..8 -> avg_out=4, peak_max=peak_min=0.

Source files
------------

// File: rtl/vedm_energy_pkg.sv
// Shared types and defaults for the windowed energy averager.
package vedm_energy_pkg;

  localparam int DATA_W = 8;

  localparam logic [DATA_W-1:0] ALARM_HI_DEF = 8'd200;
  localparam logic [DATA_W-1:0] ALARM_LO_DEF = 8'd180;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_REPORT = 2'd2
  } state_e;

endpackage

// File: rtl/vedm_peak_track.sv
// Running per-window maximum/minimum; the first sample of a window loads both.
module vedm_peak_track
  import vedm_energy_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_first,
  input  logic              ld_next,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] run_max,
  output logic [DATA_W-1:0] run_min
);

  logic [DATA_W-1:0] max_q, max_d;
  logic [DATA_W-1:0] min_q, min_d;

  always_comb begin
    max_d = max_q;
    min_d = min_q;
    if (ld_first) begin
      max_d = din;
      min_d = din;
    end else if (ld_next) begin
      if (din > max_q) max_d = din;
      if (din < min_q) min_d = din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_q <= '0;
      min_q <= '0;
    end else begin
      max_q <= max_d;
      min_q <= min_d;
    end
  end

  assign run_max = max_q;
  assign run_min = min_q;

endmodule

// File: rtl/vedm_window_avg.sv
// Averages 2^WIN_LOG2 accepted samples per window with a hysteretic level alarm.
// Optional per-window peak tracking is built when VEDM_PEAK_TRACK_EN is defined.
module vedm_window_avg
  import vedm_energy_pkg::*;
#(
  parameter int                WIN_LOG2 = 3,
  parameter logic [DATA_W-1:0] ALARM_HI = ALARM_HI_DEF,
  parameter logic [DATA_W-1:0] ALARM_LO = ALARM_LO_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  input  logic              clr,
  output logic              avg_valid,
  output logic [DATA_W-1:0] avg_out,
  output logic [DATA_W-1:0] peak_max,
  output logic [DATA_W-1:0] peak_min,
  output logic              alarm,
  output logic              busy
);

  localparam int ACC_W = DATA_W + WIN_LOG2;
  localparam int CNT_W = WIN_LOG2 + 1;
  localparam logic [CNT_W-1:0] CNT_PEN = CNT_W'((1 << WIN_LOG2) - 1);

  function automatic logic [DATA_W-1:0] window_avg(input logic [ACC_W-1:0] a);
    window_avg = DATA_W'(a >> WIN_LOG2);
  endfunction

  function automatic logic next_alarm(input logic [DATA_W-1:0] avg, input logic cur);
    if (avg >= ALARM_HI)      next_alarm = 1'b1;
    else if (avg <= ALARM_LO) next_alarm = 1'b0;
    else                      next_alarm = cur;
  endfunction

  state_e            state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] avg_q, avg_d;
  logic              avg_valid_q, avg_valid_d;
  logic              alarm_q, alarm_d;
  logic              take;
  logic              publish;

  // clr wins over acceptance and over the REPORT publish.
  assign take    = s_valid & s_ready & ~clr;
  assign publish = (state_q == ST_REPORT) & ~clr;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (take) state_d = ST_ACCUM;
      ST_ACCUM:  if (take && cnt_q == CNT_PEN) state_d = ST_REPORT;
      ST_REPORT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (clr) state_d = ST_IDLE;
  end

  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    avg_d       = avg_q;
    avg_valid_d = 1'b0;
    alarm_d     = alarm_q;
    if (clr) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (take && state_q == ST_IDLE) begin
      acc_d = ACC_W'(s_data);
      cnt_d = CNT_W'(1);
    end else if (take && state_q == ST_ACCUM) begin
      acc_d = acc_q + ACC_W'(s_data);
      cnt_d = cnt_q + CNT_W'(1);
    end else if (publish) begin
      avg_d       = window_avg(acc_q);
      avg_valid_d = 1'b1;
      alarm_d     = next_alarm(window_avg(acc_q), alarm_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      avg_q       <= '0;
      avg_valid_q <= 1'b0;
      alarm_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      avg_q       <= avg_d;
      avg_valid_q <= avg_valid_d;
      alarm_q     <= alarm_d;
    end
  end

  assign s_ready   = ena & (state_q != ST_REPORT);
  assign busy      = (state_q != ST_IDLE);
  assign avg_valid = avg_valid_q;
  assign avg_out   = avg_q;
  assign alarm     = alarm_q;

`ifdef VEDM_PEAK_TRACK_EN
  logic [DATA_W-1:0] run_max, run_min;
  logic [DATA_W-1:0] pmax_q, pmax_d;
  logic [DATA_W-1:0] pmin_q, pmin_d;

  vedm_peak_track u_peak (
    .clk      (clk),
    .rst      (rst),
    .ld_first (take & (state_q == ST_IDLE)),
    .ld_next  (take & (state_q == ST_ACCUM)),
    .din      (s_data),
    .run_max  (run_max),
    .run_min  (run_min)
  );

  always_comb begin
    pmax_d = pmax_q;
    pmin_d = pmin_q;
    if (publish) begin
      pmax_d = run_max;
      pmin_d = run_min;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pmax_q <= '0;
      pmin_q <= '0;
    end else begin
      pmax_q <= pmax_d;
      pmin_q <= pmin_d;
    end
  end

  assign peak_max = pmax_q;
  assign peak_min = pmin_q;
`else
  assign peak_max = '0;
  assign peak_min = '0;
`endif

endmodule

// File: tb/tb_vedm_window_avg.sv
// Bench for vedm_window_avg: window table, corner sequences and a randomized run
// against a queue-based window model.
module tb_vedm_window_avg;

  logic       clk = 1'b0;
  logic       rst, ena, s_valid, clr;
  logic [7:0] s_data;
  logic       s_ready, avg_valid, alarm, busy;
  logic [7:0] avg_out, peak_max, peak_min;

  always #5 clk = ~clk;

  vedm_window_avg #(.WIN_LOG2(3), .ALARM_HI(8'd200), .ALARM_LO(8'd180)) dut (
    .clk(clk), .rst(rst), .ena(ena), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .clr(clr), .avg_valid(avg_valid), .avg_out(avg_out),
    .peak_max(peak_max), .peak_min(peak_min), .alarm(alarm), .busy(busy)
  );

  typedef struct {
    string           nm;
    logic [0:7][7:0] d;
    int              avg;
    int              mx;
    int              mn;
    bit              alm;
  } win_t;

  int total = 0;
  int bad   = 0;

  // Reference model: a window is just the list of accepted samples.
  logic [7:0] win[$];
  int  pend;
  bit  m_vld, m_alarm;
  int  m_avg, m_max, m_min;
  int  p_avg, p_max, p_min;

  function automatic int pk(input int x);
`ifdef VEDM_PEAK_TRACK_EN
    return x;
`else
    return 0 * x;
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    win.delete();
    pend = 0; m_vld = 0; m_alarm = 0;
    m_avg = 0; m_max = 0; m_min = 0;
  endtask

  task automatic cyc(input bit v, input bit e, input logic [7:0] d, input bit c);
    bit in_rep;
    int sum, mx, mn;
    s_valid = v; ena = e; s_data = d; clr = c;
    #1;
    in_rep = (pend == 1);
    chk("s_ready", s_ready, e && !in_rep);
    @(posedge clk);
    m_vld = 0;
    if (c) begin
      win.delete();
      pend = 0;
    end else if (in_rep) begin
      m_vld = 1;
      m_avg = p_avg; m_max = pk(p_max); m_min = pk(p_min);
      if (p_avg >= 200)      m_alarm = 1;
      else if (p_avg <= 180) m_alarm = 0;
      pend = 0;
    end else if (v && e) begin
      win.push_back(d);
      if (win.size() == 8) begin
        sum = 0; mx = 0; mn = 255;
        foreach (win[i]) begin
          sum += int'(win[i]);
          if (int'(win[i]) > mx) mx = int'(win[i]);
          if (int'(win[i]) < mn) mn = int'(win[i]);
        end
        p_avg = sum / 8; p_max = mx; p_min = mn;
        pend = 1;
        win.delete();
      end
    end
    #1;
    chk("avg_valid", avg_valid, m_vld);
    chk("avg_out", avg_out, m_avg);
    chk("peak_max", peak_max, m_max);
    chk("peak_min", peak_min, m_min);
    chk("alarm", alarm, m_alarm);
    chk("busy", busy, (win.size() != 0) || (pend != 0));
  endtask

  task automatic run_window(input win_t w, input bit gaps);
    for (int i = 0; i < 8; i++) begin
      if (gaps) begin
        int k;
        k = int'($urandom_range(0, 3));
        for (int j = 0; j < k; j++) begin
          if ($urandom_range(0, 1) == 1) cyc(1'b0, 1'($urandom_range(0, 1)), 8'($urandom), 1'b0);
          else                           cyc(1'b1, 1'b0, 8'($urandom), 1'b0);
        end
      end
      cyc(1'b1, 1'b1, w.d[i], 1'b0);
    end
    s_valid = 1'b1; ena = 1'b1;
    #1;
    chk({w.nm, "_ready_in_report"}, s_ready, 0);
    chk({w.nm, "_no_early_pulse"}, avg_valid, 0);
    cyc(1'b1, 1'($urandom_range(0, 1)), 8'hAA, 1'b0);
    chk({w.nm, "_pulse"}, avg_valid, 1);
    chk({w.nm, "_avg"}, avg_out, w.avg);
    chk({w.nm, "_max"}, peak_max, pk(w.mx));
    chk({w.nm, "_min"}, peak_min, pk(w.mn));
    chk({w.nm, "_alarm"}, alarm, w.alm);
    cyc(1'b0, 1'b1, 8'h00, 1'b0);
    chk({w.nm, "_single_pulse"}, avg_valid, 0);
  endtask

  function automatic win_t mk(input string nm, input logic [63:0] d, input int avg,
                              input int mx, input int mn, input bit alm);
    win_t w;
    w.nm = nm; w.d = d; w.avg = avg; w.mx = mx; w.mn = mn; w.alm = alm;
    return w;
  endfunction

  win_t tbl[7];
  win_t w;

  initial begin
    tbl[0] = mk("flat100", {8{8'd100}}, 100, 100, 100, 1'b0);
    tbl[1] = mk("ramp1to8", {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8}, 4, 8, 1, 1'b0);
    tbl[2] = mk("flat255", {8{8'd255}}, 255, 255, 255, 1'b1);
    tbl[3] = mk("avg200", {8{8'd200}}, 200, 200, 200, 1'b1);
    tbl[4] = mk("avg190", {8'd185, 8'd195, 8'd190, 8'd190, 8'd180, 8'd200, 8'd190, 8'd190}, 190, 200, 180, 1'b1);
    tbl[5] = mk("avg181", {8'd181, 8'd181, 8'd181, 8'd181, 8'd181, 8'd181, 8'd181, 8'd183}, 181, 183, 181, 1'b1);
    tbl[6] = mk("avg180", {8'd187, 8'd180, 8'd180, 8'd180, 8'd180, 8'd180, 8'd180, 8'd180}, 180, 187, 180, 1'b0);

    rst = 1'b1; ena = 1'b0; s_valid = 1'b0; s_data = '0; clr = 1'b0;
    model_reset();
    #12;
    chk("rst_avg_valid", avg_valid, 0);
    chk("rst_avg_out", avg_out, 0);
    chk("rst_peak_max", peak_max, 0);
    chk("rst_peak_min", peak_min, 0);
    chk("rst_alarm", alarm, 0);
    chk("rst_busy", busy, 0);
    chk("rst_s_ready", s_ready, 0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_window(tbl[i], (i % 2) == 1);

    // Abort a partial window with clr (sample offered alongside clr is dropped).
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 8'd77, 1'b0);
    cyc(1'b1, 1'b1, 8'd99, 1'b1);
    chk("clr_idle", busy, 0);
    w = mk("after_clr50", {8{8'd50}}, 50, 50, 50, 1'b0);
    run_window(w, 1'b0);

    // clr landing in REPORT cancels the pulse and leaves outputs alone.
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 8'd10, 1'b0);
    cyc(1'b1, 1'b1, 8'd0, 1'b1);
    chk("clr_report_no_pulse", avg_valid, 0);
    chk("clr_report_avg_held", avg_out, 50);
    cyc(1'b0, 1'b1, 8'd0, 1'b0);
    chk("clr_report_still_no_pulse", avg_valid, 0);

    // Async reset mid-window after an alarm-raising window.
    w = mk("pre_rst255", {8{8'd255}}, 255, 255, 255, 1'b1);
    run_window(w, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 8'd220, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("arst_avg_out", avg_out, 0);
    chk("arst_alarm", alarm, 0);
    chk("arst_busy", busy, 0);
    chk("arst_peak_max", peak_max, 0);
    chk("arst_avg_valid", avg_valid, 0);
    model_reset();
    #2 rst = 1'b0;
    for (int i = 0; i < 12; i++) cyc(1'b0, 1'b1, 8'd0, 1'b0);
    w = mk("post_rst", {8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd17}, 10, 17, 9, 1'b0);
    run_window(w, 1'b1);

    // Randomized traffic checked cycle by cycle against the model.
    for (int blk = 0; blk < 15; blk++) begin
      int lo;
      lo = (blk % 3 == 0) ? 0 : ((blk % 3 == 1) ? 150 : 190);
      for (int i = 0; i < 200; i++)
        cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) != 0),
            8'($urandom_range(lo, 255)), 1'($urandom_range(0, 59) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
